// File: rtl/s_mux_if.sv
// s_mux_if: select/data inputs plus combinational and registered outputs of s_mux
interface s_mux_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;
  modport master (output a, b, sel, in_valid, input out, out_q, out_valid);
  modport slave  (input a, b, sel, in_valid, output out, out_q, out_valid);
endinterface

// File: rtl/s_mux.sv
// s_mux: 2:1 mux with a combinational output and a valid-qualified pipelined copy
module s_mux #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input logic     clk,
  input logic     rst,
  s_mux_if.slave  bus
);
  logic [WIDTH-1:0] mux;
  logic [WIDTH-1:0] src_d  [PIPE_STAGES];
  logic             src_v  [PIPE_STAGES];
  logic [WIDTH-1:0] data_d [PIPE_STAGES];
  logic [WIDTH-1:0] data_q [PIPE_STAGES];
  logic             vld_d  [PIPE_STAGES];
  logic             vld_q  [PIPE_STAGES];
  if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_stages
    $error("s_mux: PIPE_STAGES must be in 1..8");
  end
  assign mux     = bus.sel ? bus.b : bus.a;
  assign bus.out = mux;
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign src_d[s] = mux;
      assign src_v[s] = bus.in_valid;
    end else begin : g_next
      assign src_d[s] = data_q[s-1];
      assign src_v[s] = vld_q[s-1];
    end
    // data holds across invalid slots so out_q keeps the last valid result
    always_comb begin
      data_d[s] = src_v[s] ? src_d[s] : data_q[s];
      vld_d[s]  = src_v[s];
    end
    always_ff @(posedge clk) begin
      data_q[s] <= rst ? '0 : data_d[s];
      vld_q[s]  <= rst ? 1'b0 : vld_d[s];
    end
  end
  assign bus.out_q     = data_q[PIPE_STAGES-1];
  assign bus.out_valid = vld_q[PIPE_STAGES-1];
endmodule

// File: tb/tb_s_mux.sv
// tb_s_mux: scoreboard bench for s_mux across three width/depth configurations
module tb_s_mux;
  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  s_mux_if #(.WIDTH(1)) if1 ();
  s_mux_if #(.WIDTH(8)) if2 ();
  s_mux_if #(.WIDTH(8)) if3 ();

  s_mux #(.WIDTH(1), .PIPE_STAGES(1)) d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  s_mux #(.WIDTH(8), .PIPE_STAGES(2)) d2 (.clk(clk), .rst(rst), .bus(if2.slave));
  s_mux #(.WIDTH(8), .PIPE_STAGES(3)) d3 (.clk(clk), .rst(rst), .bus(if3.slave));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic mon(input string n, input logic v, input logic [7:0] d, inout exp_t q[$]);
    exp_t e;
    if (v) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s unexpected: got out_valid=1 data=%0h expected no output at cycle %0d", n, d, cyc);
      end else begin
        e = q.pop_front();
        chk({n, " data"}, 32'(d), 32'(e.d));
        chk({n, " cycle"}, cyc, e.due);
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s missing: got out_valid=0 expected data=%0h at cycle %0d", n, e.d, e.due);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon("d1", if1.out_valid, 8'(if1.out_q), q1);
    mon("d2", if2.out_valid, if2.out_q, q2);
    mon("d3", if3.out_valid, if3.out_q, q3);
  end

  task automatic push(input int id, input logic [7:0] d, input int lat);
    exp_t e;
    e.d   = d;
    e.due = cyc + lat;
    if (id == 1) q1.push_back(e);
    else if (id == 2) q2.push_back(e);
    else q3.push_back(e);
  endtask

  logic [7:0] tt_exp = 8'b1101_1000;
  logic [7:0] tp_a [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
  logic [7:0] tp_b [6] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
  logic [7:0] tp_e [6] = '{8'h10, 8'h81, 8'h12, 8'h83, 8'h14, 8'h85};
  logic [7:0] rs_a [5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
  logic [7:0] rs_b [5] = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
  logic [7:0] rs_e [5] = '{8'hE1, 8'h22, 8'hE3, 8'h24, 8'hE5};

  initial begin
    {if1.a, if1.b, if1.sel, if1.in_valid} = '0;
    {if2.a, if2.b, if2.sel, if2.in_valid} = '0;
    {if3.a, if3.b, if3.sel, if3.in_valid} = '0;
    repeat (2) @(negedge clk);
    chk("reset d1 out_q", 32'(if1.out_q), 0);
    chk("reset d1 out_valid", 32'(if1.out_valid), 0);
    chk("reset d2 out_q", 32'(if2.out_q), 0);
    chk("reset d3 out_valid", 32'(if3.out_valid), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {if1.a, if1.b, if1.sel} = 3'(i);
      #1;
      $display("a=%b b=%b sel=%b out=%b", if1.a, if1.b, if1.sel, if1.out);
      chk($sformatf("truth %03b", 3'(i)), 32'(if1.out), 32'(tt_exp[i]));
    end
    @(negedge clk);
    {if1.a, if1.b, if1.sel, if1.in_valid} = 4'b1001;
    push(1, 8'h01, 1);
    @(negedge clk);
    {if1.a, if1.in_valid} = 2'b00;
    @(negedge clk);
    chk("d1 hold out_valid", 32'(if1.out_valid), 0);
    chk("d1 hold out_q", 32'(if1.out_q), 1);
    @(negedge clk);
    {if2.a, if2.b, if2.sel, if2.in_valid} = {8'hA5, 8'h3C, 1'b0, 1'b1};
    push(2, 8'hA5, 2);
    #1 chk("wide sel0 out", 32'(if2.out), 32'hA5);
    @(negedge clk);
    if2.sel = 1'b1;
    push(2, 8'h3C, 2);
    #1 chk("wide sel1 out", 32'(if2.out), 32'h3C);
    @(negedge clk);
    if2.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      {if2.a, if2.b, if2.sel, if2.in_valid} = {tp_a[i], tp_b[i], 1'(i % 2), 1'b1};
      push(2, tp_e[i], 2);
      @(negedge clk);
    end
    if2.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      {if3.a, if3.b, if3.sel, if3.in_valid} = {rs_a[i], rs_b[i], 1'(~i % 2), 1'b1};
      push(3, rs_e[i], 3);
      @(negedge clk);
    end
    rst = 1'b1;
    if3.a = 8'h77;
    q1.delete();
    q2.delete();
    q3.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midreset d3 out_q", 32'(if3.out_q), 0);
    chk("midreset d3 out_valid", 32'(if3.out_valid), 0);
    chk("midreset d2 out_q", 32'(if2.out_q), 0);
    {if3.a, if3.b, if3.sel, if3.in_valid} = {8'h5A, 8'hC3, 1'b1, 1'b1};
    push(3, 8'hC3, 3);
    @(negedge clk);
    if3.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("d1 queue drained", q1.size(), 0);
    chk("d2 queue drained", q2.size(), 0);
    chk("d3 queue drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
